cache_ctrl_wb: RTL and testbench



---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_lru_set.sv | 26 ++
 rtl/cache_ctrl_wb.sv | 173 +++++++++++++++++
 tb/tb_cache_ctrl_wb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: FSM encoding, derived-width helpers and address field extraction
// shared by the cache controller and its LRU sub-module.
package cache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
  function automatic int tag_w(input int addr_w, input int offset_w, input int index_w);
    return addr_w - offset_w - index_w;
  endfunction
  function automatic int line_w(input int addr_w, input int offset_w);
    return addr_w - offset_w;
  endfunction
  function automatic int age_w(input int ways);
    return $clog2(ways);
  endfunction
  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int offset_w, input int index_w);
    return a >> (offset_w + index_w);
  endfunction
  function automatic logic [31:0] addr_index(input logic [31:0] a, input int offset_w, input int index_w);
    return (a >> offset_w) & ((32'd1 << index_w) - 32'd1);
  endfunction
  function automatic logic [31:0] addr_offset(input logic [31:0] a, input int offset_w);
    return a & ((32'd1 << offset_w) - 32'd1);
  endfunction
endpackage

// File: rtl/cache_lru_set.sv
// cache_lru_set: age update and victim choice for one set; ages stay a permutation of 0..WAYS-1.
module cache_lru_set #(
  parameter int WAYS  = 2,
  parameter int AGE_W = 1
) (
  input  logic [WAYS*AGE_W-1:0] ages,
  input  logic [WAYS-1:0]       valid,
  input  logic [AGE_W-1:0]      acc,
  output logic [WAYS*AGE_W-1:0] ages_nx,
  output logic [AGE_W-1:0]      victim
);
  logic [AGE_W-1:0] old;
  always_comb begin
    old = ages[acc*AGE_W +: AGE_W];
    victim = '0;
    ages_nx = ages;
    for (int w = WAYS - 1; w >= 0; w--)
      if (ages[w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
    // an empty way always wins over the oldest one; the lowest index is written last
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[w]) victim = AGE_W'(w);
    for (int w = 0; w < WAYS; w++)
      ages_nx[w*AGE_W +: AGE_W] = (AGE_W'(w) == acc) ? '0 :
        ages[w*AGE_W +: AGE_W] + AGE_W'(ages[w*AGE_W +: AGE_W] < old);
  end
endmodule

// File: rtl/cache_ctrl_wb.sv
// cache_ctrl_wb: N-way set-associative write-back/write-allocate cache controller
// with per-set LRU, word-serial memory bursts and saturating performance counters.
module cache_ctrl_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int WORD_W   = 16,
  parameter int OFFSET_W = 4,
  parameter int INDEX_W  = 3,
  parameter int WAYS     = 2,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [WORD_W-1:0]          cpu_wdata,
  output logic                       cpu_ready,
  output logic                       cpu_done,
  output logic [WORD_W-1:0]          cpu_rdata,
  output logic                       cpu_hit,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-OFFSET_W-1:0] mem_line_addr,
  output logic [OFFSET_W-1:0]        mem_beat,
  output logic [WORD_W-1:0]          mem_wdata,
  input  logic                       mem_ready,
  input  logic [WORD_W-1:0]          mem_rdata,
  output logic [CNT_W-1:0]           hit_count,
  output logic [CNT_W-1:0]           miss_count,
  output logic [CNT_W-1:0]           wb_count
);
  localparam int TAG_W = tag_w(ADDR_W, OFFSET_W, INDEX_W);
  localparam int AGE_W = age_w(WAYS);
  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  state_t state;
  logic [ADDR_W-1:0] req_addr;
  logic req_we;
  logic [WORD_W-1:0] req_wdata;
  logic [AGE_W-1:0] way, hit_way, victim, acc_way;
  logic hit, last;
  logic [WAYS-1:0] valid [SETS];
  logic [WAYS-1:0] dirty [SETS];
  logic [WAYS*AGE_W-1:0] ages [SETS];
  logic [WAYS*AGE_W-1:0] ages_nx;
  logic [TAG_W-1:0] tags [SETS][WAYS];
  logic [WORD_W-1:0] data [SETS][WAYS][WORDS];
  logic [TAG_W-1:0] req_tag;
  logic [INDEX_W-1:0] idx;
  logic [OFFSET_W-1:0] off;
  assign req_tag = TAG_W'(addr_tag(32'(req_addr), OFFSET_W, INDEX_W));
  assign idx     = INDEX_W'(addr_index(32'(req_addr), OFFSET_W, INDEX_W));
  assign off     = OFFSET_W'(addr_offset(32'(req_addr), OFFSET_W));
  assign last    = &mem_beat;
  assign acc_way = state == LOOKUP ? hit_way : way;
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[idx][w] && tags[idx][w] == req_tag) begin
        hit = 1'b1;
        hit_way = AGE_W'(w);
      end
  end
  cache_lru_set #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
    .ages(ages[idx]), .valid(valid[idx]), .acc(acc_way), .ages_nx(ages_nx), .victim(victim)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req_addr <= '0;
      req_we <= 1'b0;
      req_wdata <= '0;
      way <= '0;
      cpu_ready <= 1'b1;
      cpu_done <= 1'b0;
      cpu_hit <= 1'b0;
      cpu_rdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_line_addr <= '0;
      mem_beat <= '0;
      mem_wdata <= '0;
      hit_count <= '0;
      miss_count <= '0;
      wb_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) ages[s][w*AGE_W +: AGE_W] <= AGE_W'(w);
      end
    end else begin
      cpu_done <= 1'b0;
      case (state)
        IDLE: if (cpu_req) begin
          req_addr <= cpu_addr;
          req_we <= cpu_we;
          req_wdata <= cpu_wdata;
          cpu_ready <= 1'b0;
          state <= LOOKUP;
        end
        LOOKUP: if (hit) begin
          cpu_done <= 1'b1;
          cpu_hit <= 1'b1;
          way <= hit_way;
          if (req_we) dirty[idx][hit_way] <= 1'b1;
          else cpu_rdata <= data[idx][hit_way][off];
          ages[idx] <= ages_nx;
          if (~&hit_count) hit_count <= hit_count + 1'b1;
          cpu_ready <= 1'b1;
          state <= IDLE;
        end else begin
          if (~&miss_count) miss_count <= miss_count + 1'b1;
          way <= victim;
          mem_req <= 1'b1;
          mem_beat <= '0;
          if (valid[idx][victim] && dirty[idx][victim]) begin
            mem_we <= 1'b1;
            mem_line_addr <= {tags[idx][victim], idx};
            mem_wdata <= data[idx][victim][0];
            state <= WRITEBACK;
          end else begin
            mem_we <= 1'b0;
            mem_line_addr <= {req_tag, idx};
            state <= REFILL;
          end
        end
        WRITEBACK: if (mem_ready) begin
          mem_beat <= mem_beat + 1'b1;
          mem_wdata <= data[idx][way][mem_beat + 1'b1];
          if (last) begin
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_wdata <= '0;
            mem_line_addr <= {req_tag, idx};
            dirty[idx][way] <= 1'b0;
            if (~&wb_count) wb_count <= wb_count + 1'b1;
            state <= REFILL;
          end
        end
        // entered from WRITEBACK with mem_req low: that one idle cycle separates the bursts
        REFILL: if (!mem_req) mem_req <= 1'b1;
        else if (mem_ready) begin
          mem_beat <= mem_beat + 1'b1;
          if (last) begin
            mem_req <= 1'b0;
            valid[idx][way] <= 1'b1;
            dirty[idx][way] <= 1'b0;
            state <= RESPOND;
          end
        end
        RESPOND: begin
          cpu_done <= 1'b1;
          cpu_hit <= 1'b0;
          if (req_we) dirty[idx][way] <= 1'b1;
          else cpu_rdata <= data[idx][way][off];
          ages[idx] <= ages_nx;
          cpu_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && req_we) data[idx][hit_way][off] <= req_wdata;
    if (state == REFILL && mem_req && mem_ready) data[idx][way][mem_beat] <= mem_rdata;
    if (state == REFILL && mem_req && mem_ready && last) tags[idx][way] <= req_tag;
    if (state == RESPOND && req_we) data[idx][way][off] <= req_wdata;
  end
endmodule

// File: tb/tb_cache_ctrl_wb.sv
// tb_cache_ctrl_wb: directed vector table plus randomized traffic, checked against a
// recency-list cache model and a flat CPU-visible memory image.
module tb_cache_ctrl_wb;
  localparam int WAYS = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic cpu_ready, cpu_done, cpu_hit;
  logic [15:0] cpu_rdata;
  logic mem_req, mem_we;
  logic [7:0] mem_line_addr;
  logic [3:0] mem_beat;
  logic [15:0] mem_wdata, mem_rdata;
  logic mem_ready = 1'b1;
  logic [15:0] hit_count, miss_count, wb_count;
  logic cpu_ready2, cpu_done2, cpu_hit2, mem_req2, mem_we2;
  logic [15:0] cpu_rdata2, mem_wdata2;
  logic [7:0] mem_line_addr2;
  logic [3:0] mem_beat2;
  logic [1:0] hit2, miss2, wb2;
  cache_ctrl_wb dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_line_addr(mem_line_addr), .mem_beat(mem_beat),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );
  cache_ctrl_wb #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready2), .cpu_done(cpu_done2), .cpu_rdata(cpu_rdata2), .cpu_hit(cpu_hit2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_line_addr(mem_line_addr2), .mem_beat(mem_beat2),
    .mem_wdata(mem_wdata2), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hit2), .miss_count(miss2), .wb_count(wb2)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic we; logic [7:0] line; logic [3:0] beat;} xfer_t;
  logic [15:0] memory [4096];
  xfer_t xlog [$];
  bit req_trace [$];
  assign mem_rdata = memory[{mem_line_addr, mem_beat}];
  always @(posedge clk) begin
    req_trace.push_back(mem_req);
    if (mem_req && mem_ready) begin
      xlog.push_back({mem_we, mem_line_addr, mem_beat});
      if (mem_we) memory[{mem_line_addr, mem_beat}] = mem_wdata;
    end
  end
  int stall_beat = 6, stall_left = 0;
  bit rand_ready = 0;
  always @(negedge clk)
    if (stall_left > 0 && mem_req && !mem_we && int'(mem_beat) == stall_beat) begin
      mem_ready = 1'b0;
      stall_left--;
    end else mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  int rec [8][WAYS];
  int cnt [8];
  bit dirty_l [256];
  logic [15:0] gold [4096];
  int m_hits, m_miss, m_wb;
  int checks = 0, passes = 0;
  bit stuck = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic model_reset();
    for (int s = 0; s < 8; s++) cnt[s] = 0;
    for (int l = 0; l < 256; l++) dirty_l[l] = 0;
    for (int i = 0; i < 4096; i++) gold[i] = memory[i];
    m_hits = 0; m_miss = 0; m_wb = 0;
  endtask
  task automatic model(input bit we, input logic [11:0] a, input logic [15:0] wd,
                       output bit h, output bit wb, output int vline, output logic [15:0] rd);
    int s, line, pos;
    line = int'(a[11:4]);
    s = line % 8;
    pos = -1;
    for (int i = 0; i < cnt[s]; i++) if (rec[s][i] == line) pos = i;
    h = pos >= 0; wb = 0; vline = 0;
    if (h) m_hits++;
    else begin
      m_miss++;
      if (cnt[s] < WAYS) begin pos = cnt[s]; cnt[s]++; end
      else begin
        pos = WAYS - 1;
        vline = rec[s][pos];
        wb = dirty_l[vline];
        dirty_l[vline] = 0;
        if (wb) m_wb++;
      end
    end
    for (int i = pos; i > 0; i--) rec[s][i] = rec[s][i-1];
    rec[s][0] = line;
    if (we) begin gold[a] = wd; dirty_l[line] = 1; end
    rd = gold[a];
  endtask
  task automatic issue(input bit we, input logic [11:0] a, input logic [15:0] wd);
    int n = 0;
    if (stuck) return;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    while (!cpu_ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin chk("accept_timeout", 1, 0); stuck = 1; cpu_req = 1'b0; return; end
    xlog.delete();
    req_trace.delete();
    @(negedge clk);
    cpu_req = 1'b0;
  endtask
  task automatic complete(input bit we, input logic [11:0] a, input logic [15:0] wd,
                          input int exp_lat, input string tag);
    int lat = 0, vl, n, gaps = 0, first = -1, lst = -1;
    bit busy_ok = 1, burst_ok = 1, h, wb;
    logic [15:0] rd;
    xfer_t e;
    if (stuck) return;
    while (!cpu_done && lat < 2000) begin
      if (cpu_ready) busy_ok = 0;
      @(negedge clk);
      lat++;
    end
    if (!cpu_done) begin chk({tag, "_done_timeout"}, 0, 1); stuck = 1; return; end
    model(we, a, wd, h, wb, vl, rd);
    chk({tag, "_hit"}, cpu_hit, h);
    if (!we) chk({tag, "_rdata"}, cpu_rdata, rd);
    chk({tag, "_ready_low"}, busy_ok, 1);
    if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
    n = h ? 0 : (wb ? 32 : 16);
    chk({tag, "_xfers"}, xlog.size(), n);
    for (int i = 0; i < xlog.size() && i < n; i++) begin
      e = (wb && i < 16) ? {1'b1, 8'(vl), 4'(i)} : {1'b0, a[11:4], 4'(i % 16)};
      if (xlog[i] !== e) burst_ok = 0;
    end
    chk({tag, "_burst_seq"}, burst_ok, 1);
    for (int i = 0; i < req_trace.size(); i++)
      if (req_trace[i]) begin if (first < 0) first = i; lst = i; end
    for (int i = first; i >= 0 && i <= lst; i++) if (!req_trace[i]) gaps++;
    chk({tag, "_req_gap"}, gaps, wb ? 1 : 0);
  endtask
  typedef struct {bit we; logic [11:0] addr; logic [15:0] wd; int stall; bit hit; int lat;} vec_t;
  vec_t tbl [7];
  initial begin
    int n;
    logic [11:0] a;
    logic [15:0] d;
    bit w;
    tbl[0] = '{1'b0, 12'h123, 16'h0000, 0, 1'b0, 18};
    tbl[1] = '{1'b0, 12'h125, 16'h0000, 0, 1'b1, 1};
    tbl[2] = '{1'b1, 12'h123, 16'hBEEF, 0, 1'b1, 1};
    tbl[3] = '{1'b0, 12'h1A0, 16'h0000, 0, 1'b0, 18};
    tbl[4] = '{1'b0, 12'h2A0, 16'h0000, 0, 1'b0, 35};
    tbl[5] = '{1'b0, 12'h123, 16'h0000, 0, 1'b0, 18};
    tbl[6] = '{1'b0, 12'h345, 16'h0000, 5, 1'b0, 23};
    for (int i = 0; i < 4096; i++) memory[i] = 16'($urandom);
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_cpu_done", cpu_done, 0);
    chk("rst_counters", {hit_count, miss_count}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", cpu_ready, 1);
    for (int i = 0; i < 7; i++) begin
      stall_left = tbl[i].stall;
      issue(tbl[i].we, tbl[i].addr, tbl[i].wd);
      complete(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].lat, $sformatf("v%0d", i));
      chk($sformatf("v%0d_tbl_hit", i), cpu_hit, tbl[i].hit);
    end
    chk("tbl_hit_count", hit_count, 2);
    chk("tbl_miss_count", miss_count, 5);
    chk("tbl_wb_count", wb_count, 1);
    chk("tbl_wb_data", memory[12'h123], 16'hBEEF);
    chk("tbl_hit2", hit2, 2);
    chk("tbl_reread_beef", cpu_rdata, 16'h0000 | gold[12'h345]);
    issue(1'b0, 12'h567, 16'h0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h568;
    complete(1'b0, 12'h567, 16'h0, 18, "busyA");
    xlog.delete();
    req_trace.delete();
    @(negedge clk);
    cpu_req = 1'b0;
    complete(1'b0, 12'h568, 16'h0, 1, "busyB");
    issue(1'b1, 12'h123, 16'hCAFE);
    complete(1'b1, 12'h123, 16'hCAFE, 1, "pre_w");
    issue(1'b0, 12'h3A0, 16'h0);
    complete(1'b0, 12'h3A0, 16'h0, 18, "pre_r");
    issue(1'b0, 12'h4A0, 16'h0);
    n = 0;
    while (!(mem_req && mem_we && mem_beat == 4'd7) && n < 200) begin @(negedge clk); n++; end
    chk("rst_reach_wb_beat7", mem_line_addr, 8'h12);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_line_beat", {mem_line_addr, mem_beat}, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_cpu", {cpu_done, cpu_hit, cpu_rdata}, 0);
    chk("mid_rst_counters", {hit_count, miss_count, wb_count}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_rst_ready", cpu_ready, 1);
    issue(1'b0, 12'h123, 16'h0);
    complete(1'b0, 12'h123, 16'h0, 18, "post_rst");
    chk("post_rst_cafe", cpu_rdata, 16'hCAFE);
    rand_ready = 1;
    for (int i = 0; i < 250 && !stuck; i++) begin
      w = $urandom_range(0, 2) == 0;
      a = {3'b000, 2'($urandom), 3'($urandom), 4'($urandom)};
      d = 16'($urandom);
      issue(w, a, d);
      complete(w, a, d, 0, $sformatf("rnd%0d", i));
    end
    chk("end_hit_count", hit_count, m_hits);
    chk("end_miss_count", miss_count, m_miss);
    chk("end_wb_count", wb_count, m_wb);
    chk("sat_hit2", hit2, m_hits > 3 ? 3 : m_hits);
    chk("sat_miss2", miss2, m_miss > 3 ? 3 : m_miss);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
